// File: rtl/lift_scheduler.sv
// Three-floor lift controller with collective up/down scan.
// All state changes on the falling clock edge; reset is asynchronous and active low.
module lift_scheduler #(
  parameter int unsigned TRAVEL_CYC = 4,
  parameter int unsigned DOOR_CYC   = 3
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic [2:0] call_req,
  input  logic [2:0] car_req,
  output logic [1:0] floor_out,
  output logic       moving,
  output logic       dir_up,
  output logic       dir_dn,
  output logic       door_open,
  output logic [2:0] pending
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MOVE_UP = 2'd1;
  localparam logic [1:0] MOVE_DN = 2'd2;
  localparam logic [1:0] DOOR    = 2'd3;

  localparam logic [3:0] TravelLast = 4'(TRAVEL_CYC - 1);
  localparam logic [3:0] DoorLast   = 4'(DOOR_CYC - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] floor_q, floor_d;
  logic [2:0] pend_q, pend_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_up_q, last_up_d;

  logic [2:0] req;
  logic [2:0] p_all;
  logic [1:0] nfloor;
  logic [1:0] nxt;
  logic       decide_now;

  function automatic logic [2:0] fbit(input logic [1:0] f);
    return 3'b001 << f;
  endfunction

  function automatic logic above(input logic [2:0] p, input logic [1:0] f);
    unique case (f)
      2'd0:    return p[2] | p[1];
      2'd1:    return p[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic below(input logic [2:0] p, input logic [1:0] f);
    unique case (f)
      2'd2:    return p[1] | p[0];
      2'd1:    return p[0];
      default: return 1'b0;
    endcase
  endfunction

  // Stop here if wanted, else prefer last direction, else reverse, else rest.
  function automatic logic [1:0] decide(input logic [2:0] p, input logic [1:0] f,
                                        input logic up);
    logic a;
    logic b;
    a = above(p, f);
    b = below(p, f);
    if ((p & fbit(f)) != 3'b000) return DOOR;
    else if (up && a)            return MOVE_UP;
    else if (!up && b)           return MOVE_DN;
    else if (a)                  return MOVE_UP;
    else if (b)                  return MOVE_DN;
    else                         return IDLE;
  endfunction

  always_comb begin
    req        = call_req | car_req;
    p_all      = pend_q | req;
    state_d    = state_q;
    floor_d    = floor_q;
    cnt_d      = cnt_q;
    last_up_d  = last_up_q;
    pend_d     = p_all;
    nfloor     = floor_q;
    nxt        = IDLE;
    decide_now = 1'b0;

    case (state_q)
      IDLE: begin
        decide_now = 1'b1;
      end
      MOVE_UP, MOVE_DN: begin
        if (cnt_q == TravelLast) begin
          nfloor  = (state_q == MOVE_UP) ? floor_q + 2'd1 : floor_q - 2'd1;
          floor_d = nfloor;
          cnt_d   = 4'd0;
          if ((p_all & fbit(nfloor)) != 3'b000) begin
            state_d = DOOR;
            pend_d  = p_all & ~fbit(nfloor);
          end else if ((state_q == MOVE_UP) ? above(p_all, nfloor)
                                            : below(p_all, nfloor)) begin
            state_d = state_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        // A call for the open floor holds the door rather than queueing a revisit.
        pend_d = p_all & ~fbit(floor_q);
        if ((req & fbit(floor_q)) != 3'b000) begin
          cnt_d = 4'd0;
        end else if (cnt_q == DoorLast) begin
          decide_now = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase

    if (decide_now) begin
      nxt     = decide(p_all, floor_q, last_up_q);
      state_d = nxt;
      cnt_d   = 4'd0;
      if (nxt == DOOR)    pend_d    = p_all & ~fbit(floor_q);
      if (nxt == MOVE_UP) last_up_d = 1'b1;
      if (nxt == MOVE_DN) last_up_d = 1'b0;
    end
  end

  always_ff @(negedge CLK or negedge RES) begin
    if (!RES) begin
      state_q   <= IDLE;
      floor_q   <= 2'd0;
      pend_q    <= 3'b000;
      cnt_q     <= 4'd0;
      last_up_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      last_up_q <= last_up_d;
    end
  end

  assign floor_out = floor_q;
  assign pending   = pend_q;
  assign dir_up    = (state_q == MOVE_UP);
  assign dir_dn    = (state_q == MOVE_DN);
  assign moving    = dir_up | dir_dn;
  assign door_open = (state_q == DOOR);

endmodule

// File: doc/lift_scheduler.md
LIFT_SCHEDULER -- requirements
Module: lift_scheduler

Interface
REQ-001 SHALL have parameter TRAVEL_CYC, default 4: clock cycles to move one floor (legal range 1..15).
REQ-002 SHALL have parameter DOOR_CYC, default 3: clock cycles the door stays open per stop (legal range 1..15).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the falling edge.
REQ-004 SHALL have port RES, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port call_req, input, 3 bits: hall call per floor (bit0 = first floor, bit2 = third floor); sampled each edge, a high bit sets that floor's pending flag.
REQ-006 SHALL have port car_req, input, 3 bits: cabin button per floor, same semantics as call_req.
REQ-007 SHALL have port floor_out, output, 2 bits: current floor (00 = first, 01 = second, 10 = third; 11 never driven).
REQ-008 SHALL have port moving, output, 1 bit: high while in MOVE_UP or MOVE_DN.
REQ-009 SHALL have port dir_up, output, 1 bit: high in MOVE_UP.
REQ-010 SHALL have port dir_dn, output, 1 bit: high in MOVE_DN.
REQ-011 SHALL have port door_open, output, 1 bit: high in DOOR.
REQ-012 SHALL have port pending, output, 3 bits: latched, unserved requests per floor.

Function
REQ-013 SHALL implement states IDLE, MOVE_UP, MOVE_DN, DOOR; all outputs registered or decoded from registered state only.
REQ-014 Pending flags SHALL be set by (call_req | car_req) and cleared only when the floor is served; set and clear in the same edge for the served floor resolves to clear.
REQ-015 Decision rule (IDLE, and DOOR exit): pending at current floor -> DOOR; else pending in last_dir direction -> move that way; else pending in opposite direction -> move that way and flip last_dir; else IDLE.
REQ-016 IDLE with request at current floor SHALL raise door_open on the next edge, never latching the flag.
REQ-017 MOVE: step counter cleared on entry, incremented each edge; on the edge where count = TRAVEL_CYC-1, floor_out SHALL step by one and the arrival decision SHALL be taken on that same edge.
REQ-018 Arrival decision: pending at new floor -> DOOR, clearing that flag; else pending further in current direction -> keep moving (counter restarts); else IDLE.
REQ-019 moving SHALL therefore be high exactly TRAVEL_CYC cycles per floor traversed.
REQ-020 floor_out SHALL never go above 10 or below 00; MOVE_UP is entered only from floors 00/01, MOVE_DN only from 01/10.
REQ-021 DOOR: door_open high for DOOR_CYC cycles; a new request for the current floor arriving during DOOR SHALL restart the door counter and SHALL NOT set the pending flag.
REQ-022 On the edge where the door count = DOOR_CYC-1, the REQ-015 decision SHALL apply (DOOR -> MOVE or IDLE directly, no IDLE bubble).
REQ-023 Requests for other floors during MOVE/DOOR SHALL be latched and served per REQ-015/018 (collective scan: finish current direction before reversing).

Reset
REQ-024 RES low SHALL immediately force state IDLE, floor_out 00, pending 000, moving/dir_up/dir_dn/door_open 0, counters 0, last_dir up, independent of CLK.
REQ-025 Reset mid-move or mid-door SHALL discard all pending requests; operation resumes on the first falling edge after RES rises.

Verification (TRAVEL_CYC=4, DOOR_CYC=3)
REQ-026 Assert RES low during MOVE -> floor_out=00, moving=0, door_open=0, pending=000 without waiting for a CLK edge.
REQ-027 IDLE at 00, car_req=001 for one cycle -> door_open=1 for exactly 3 cycles, pending stays 000, then IDLE.
REQ-028 IDLE at 00, call_req=100 one cycle -> moving=dir_up=1 for 8 cycles, floor_out 01 after 4 edges, 10 after 8, door_open 3 cycles, pending 100->000 at arrival.
REQ-029 Moving up from 00 toward 10, call_req=001 pulsed while floor_out=01 -> car continues to 10, serves it, then dir_dn for 8 cycles to 00, door opens.
REQ-030 During DOOR at 01 (2nd door cycle), car_req=010 pulsed -> door counter restarts, door_open high 3 more cycles, pending bit1 stays 0.
REQ-031 IDLE at 01, call_req=101 same cycle, last_dir up -> serves 10 first, then reverses to 00; pending sequence 101 -> 001 -> 000.
